video_timing_gen: RTL

Runtime-reconfigurable raster timing generator, successor to the fixed-parameter sync generator. It produces pixel/line counters, sync, active-display, new-frame and start-of-line strobes, plus a frame counter. Timing and sync polarity are loadable at runtime through a valid/ready config port, and changes take effect only at frame boundaries. It sits at the head of the video pipeline, driving the pixel pipeline and the TMDS encoder.

---
 rtl/video_timing_gen.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/video_timing_gen.sv
// ----------------------------------------------------------------------------
// video_timing_gen
//
// Raster timing generator whose timing can be changed while it runs. It
// produces pixel and line counters, sync pulses at a chosen polarity, an
// active-display flag, new-frame and start-of-line strobes, and a frame
// counter. A new timing set arrives through a valid/ready port and is
// validated. It is then parked in a shadow copy and swapped in only at the
// last pixel of a frame, so a frame is never partly drawn with mixed timing.
//
// Ports
//   pixel_clk_in          pixel clock
//   rst_in                synchronous active-high reset (restores DEF_* timing)
//   en_in                 count enable; low freezes every counter
//   cfg_valid_in          config offer
//   cfg_ready_out         config accepted on cfg_valid_in && cfg_ready_out
//   cfg_*_h_in            horizontal active / front porch / sync / back porch
//   cfg_*_v_in            vertical active / front porch / sync / back porch
//   cfg_hs_pol_in         hsync polarity (1 = active-high)
//   cfg_vs_pol_in         vsync polarity (1 = active-high)
//   cfg_pending_out       a validated config is waiting for the frame end
//   cfg_err_out           one-cycle pulse: the last accepted offer was invalid
//   hcount_out            pixel index within the line
//   vcount_out            line index within the frame
//   hs_out, vs_out        sync outputs at the active polarity
//   ad_out                active display
//   nf_out                new-frame strobe (first blanking pixel after active)
//   sol_out               start of an active line
//   fc_out                frame counter, modulo FPS
// ----------------------------------------------------------------------------
module video_timing_gen #(
    parameter int H_WIDTH      = 12,
    parameter int V_WIDTH      = 11,
    parameter int FPS          = 60,
    parameter int DEF_ACTIVE_H = 1280,
    parameter int DEF_H_FP     = 110,
    parameter int DEF_H_SYNC   = 40,
    parameter int DEF_H_BP     = 220,
    parameter int DEF_ACTIVE_V = 720,
    parameter int DEF_V_FP     = 5,
    parameter int DEF_V_SYNC   = 5,
    parameter int DEF_V_BP     = 20,
    parameter bit DEF_HS_POL   = 1'b1,
    parameter bit DEF_VS_POL   = 1'b1
) (
    input  logic                     pixel_clk_in,
    input  logic                     rst_in,
    input  logic                     en_in,
    input  logic                     cfg_valid_in,
    output logic                     cfg_ready_out,
    input  logic [H_WIDTH-1:0]       cfg_active_h_in,
    input  logic [H_WIDTH-1:0]       cfg_h_fp_in,
    input  logic [H_WIDTH-1:0]       cfg_h_sync_in,
    input  logic [H_WIDTH-1:0]       cfg_h_bp_in,
    input  logic [V_WIDTH-1:0]       cfg_active_v_in,
    input  logic [V_WIDTH-1:0]       cfg_v_fp_in,
    input  logic [V_WIDTH-1:0]       cfg_v_sync_in,
    input  logic [V_WIDTH-1:0]       cfg_v_bp_in,
    input  logic                     cfg_hs_pol_in,
    input  logic                     cfg_vs_pol_in,
    output logic                     cfg_pending_out,
    output logic                     cfg_err_out,
    output logic [H_WIDTH-1:0]       hcount_out,
    output logic [V_WIDTH-1:0]       vcount_out,
    output logic                     hs_out,
    output logic                     vs_out,
    output logic                     ad_out,
    output logic                     nf_out,
    output logic                     sol_out,
    output logic [$clog2(FPS)-1:0]   fc_out
);

    localparam int FC_W = $clog2(FPS);
    // Two spare bits so that four full-scale fields can be summed and any
    // overflow of the counter range is visible.
    localparam int HS_W = H_WIDTH + 2;
    localparam int VS_W = V_WIDTH + 2;

    // Field order in every timing array: 0 active, 1 front porch,
    // 2 sync, 3 back porch.
    logic [H_WIDTH-1:0] act_h_reg [4];
    logic [V_WIDTH-1:0] act_v_reg [4];
    logic               act_hpol_reg;
    logic               act_vpol_reg;
    logic [H_WIDTH-1:0] shd_h_reg [4];
    logic [V_WIDTH-1:0] shd_v_reg [4];
    logic               shd_hpol_reg;
    logic               shd_vpol_reg;
    logic [H_WIDTH-1:0] cfg_h [4];
    logic [V_WIDTH-1:0] cfg_v [4];

    logic [H_WIDTH-1:0] hcount_reg;
    logic [V_WIDTH-1:0] vcount_reg;
    logic [FC_W-1:0]    fc_reg;
    logic               pending_reg;
    logic               err_reg;
    logic               hold_reg;

    logic [HS_W-1:0]    th;
    logic [VS_W-1:0]    tv;
    logic [HS_W-1:0]    cfg_th;
    logic [VS_W-1:0]    cfg_tv;
    logic [HS_W-1:0]    h_sync_start;
    logic [HS_W-1:0]    h_sync_end;
    logic [VS_W-1:0]    v_sync_start;
    logic [VS_W-1:0]    v_sync_end;
    logic               h_last;
    logic               v_last;
    logic               adv;
    logic               capture;
    logic               cfg_bad;
    logic               apply;

    assign cfg_h[0] = cfg_active_h_in;
    assign cfg_h[1] = cfg_h_fp_in;
    assign cfg_h[2] = cfg_h_sync_in;
    assign cfg_h[3] = cfg_h_bp_in;
    assign cfg_v[0] = cfg_active_v_in;
    assign cfg_v[1] = cfg_v_fp_in;
    assign cfg_v[2] = cfg_v_sync_in;
    assign cfg_v[3] = cfg_v_bp_in;

    // Frame totals for the running timing and for the timing on offer.
    always_comb begin
        th     = '0;
        tv     = '0;
        cfg_th = '0;
        cfg_tv = '0;
        for (int i = 0; i < 4; i++) begin
            th     = th + HS_W'(act_h_reg[i]);
            tv     = tv + VS_W'(act_v_reg[i]);
            cfg_th = cfg_th + HS_W'(cfg_h[i]);
            cfg_tv = cfg_tv + VS_W'(cfg_v[i]);
        end
    end

    assign h_sync_start = HS_W'(act_h_reg[0]) + HS_W'(act_h_reg[1]);
    assign h_sync_end   = h_sync_start + HS_W'(act_h_reg[2]);
    assign v_sync_start = VS_W'(act_v_reg[0]) + VS_W'(act_v_reg[1]);
    assign v_sync_end   = v_sync_start + VS_W'(act_v_reg[2]);

    assign h_last = (HS_W'(hcount_reg) == th - HS_W'(1));
    assign v_last = (VS_W'(vcount_reg) == tv - VS_W'(1));

    // The cycle right after reset is a hold cycle: counters stay at 0,0.
    assign adv = en_in && !hold_reg && !rst_in;

    assign cfg_ready_out = !pending_reg && !rst_in;
    assign capture       = cfg_valid_in && cfg_ready_out;
    // A zero active or sync width, or a total that does not fit the counter,
    // would produce a degenerate raster.
    assign cfg_bad = (cfg_h[0] == '0) || (cfg_h[2] == '0) ||
                     (cfg_v[0] == '0) || (cfg_v[2] == '0) ||
                     (cfg_th >= HS_W'(1 << H_WIDTH)) ||
                     (cfg_tv >= VS_W'(1 << V_WIDTH));
    // The swap lands exactly on the last pixel of the frame, so the next
    // cycle is pixel 0,0 of a frame drawn entirely with the new timing.
    assign apply = adv && pending_reg && h_last && v_last;

    assign ad_out  = (hcount_reg < act_h_reg[0]) && (vcount_reg < act_v_reg[0]);
    assign hs_out  = ((HS_W'(hcount_reg) >= h_sync_start) && (HS_W'(hcount_reg) < h_sync_end))
                     ? act_hpol_reg : !act_hpol_reg;
    assign vs_out  = ((VS_W'(vcount_reg) >= v_sync_start) && (VS_W'(vcount_reg) < v_sync_end))
                     ? act_vpol_reg : !act_vpol_reg;
    // Strobes are qualified by adv so a freeze can never stretch them.
    assign nf_out  = adv && (hcount_reg == act_h_reg[0]) && (vcount_reg == act_v_reg[0]);
    assign sol_out = adv && (hcount_reg == '0) && (vcount_reg < act_v_reg[0]);

    assign hcount_out      = hcount_reg;
    assign vcount_out      = vcount_reg;
    assign fc_out          = fc_reg;
    assign cfg_pending_out = pending_reg;
    assign cfg_err_out     = err_reg;

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            hcount_reg   <= '0;
            vcount_reg   <= '0;
            fc_reg       <= '0;
            pending_reg  <= 1'b0;
            err_reg      <= 1'b0;
            hold_reg     <= 1'b1;
            act_h_reg[0] <= H_WIDTH'(DEF_ACTIVE_H);
            act_h_reg[1] <= H_WIDTH'(DEF_H_FP);
            act_h_reg[2] <= H_WIDTH'(DEF_H_SYNC);
            act_h_reg[3] <= H_WIDTH'(DEF_H_BP);
            act_v_reg[0] <= V_WIDTH'(DEF_ACTIVE_V);
            act_v_reg[1] <= V_WIDTH'(DEF_V_FP);
            act_v_reg[2] <= V_WIDTH'(DEF_V_SYNC);
            act_v_reg[3] <= V_WIDTH'(DEF_V_BP);
            act_hpol_reg <= DEF_HS_POL;
            act_vpol_reg <= DEF_VS_POL;
        end else begin
            hold_reg <= 1'b0;
            err_reg  <= capture && cfg_bad;
            // Capture only happens with pending low and apply only with
            // pending high, so these two never collide.
            if (capture && !cfg_bad) begin
                pending_reg <= 1'b1;
            end
            if (adv) begin
                if (nf_out) begin
                    fc_reg <= (fc_reg == FC_W'(FPS - 1)) ? '0 : fc_reg + FC_W'(1);
                end
                if (apply) begin
                    pending_reg <= 1'b0;
                    hcount_reg  <= '0;
                    vcount_reg  <= '0;
                    for (int i = 0; i < 4; i++) begin
                        act_h_reg[i] <= shd_h_reg[i];
                        act_v_reg[i] <= shd_v_reg[i];
                    end
                    act_hpol_reg <= shd_hpol_reg;
                    act_vpol_reg <= shd_vpol_reg;
                end else if (h_last) begin
                    hcount_reg <= '0;
                    vcount_reg <= v_last ? '0 : vcount_reg + V_WIDTH'(1);
                end else begin
                    hcount_reg <= hcount_reg + H_WIDTH'(1);
                end
            end
        end
    end

    // The shadow copy carries no reset; it is only read once pending is set.
    always_ff @(posedge pixel_clk_in) begin
        if (capture && !cfg_bad) begin
            for (int i = 0; i < 4; i++) begin
                shd_h_reg[i] <= cfg_h[i];
                shd_v_reg[i] <= cfg_v[i];
            end
            shd_hpol_reg <= cfg_hs_pol_in;
            shd_vpol_reg <= cfg_vs_pol_in;
        end
    end

endmodule
